arb_xfer_ctrl: RTL and testbench

Downstream consumer of the 4-input fixed-priority arbiter's 2-bit grant. Locks onto the granted requestor and moves its data burst beat by beat into a single registered output stage with valid/ready handshake. Holds ownership until the burst's last beat drains, then releases for the next arbitration. Grant changes during a burst are ignored.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_out_stage.sv | 66 ++++++
 rtl/arb_xfer_ctrl.sv | 118 +++++++++++
 tb/tb_arb_xfer_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the arbiter and its transfer controller
// Holds the requestor count, the encoded grant type and the transfer FSM states.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] gnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/arb_out_stage.sv
// rtl/arb_out_stage.sv - one-entry registered output slice with valid/ready
// Ports:
//   arb_clk, arb_rst_n    clock, asynchronous active-low reset
//   load                  capture in_* this edge; only asserted when the slot is free or draining
//   in_data/in_src/in_last  beat presented by the controller
//   out_ready             downstream accepts the held beat
//   out_valid/out_data/out_src/out_last  registered beat
module arb_out_stage
  import arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  gnt_t              in_src,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output gnt_t              out_src,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  gnt_t              src_q, src_d;
  logic              last_q, last_d;

  // Payload only moves on load, so it stays frozen while the beat waits for ready.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      src_d   = in_src;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_last  = last_q;

endmodule

// File: rtl/arb_xfer_ctrl.sv
// rtl/arb_xfer_ctrl.sv - locks onto the arbiter grant and streams the owner's burst out
// Ports:
//   arb_clk, arb_rst_n   clock, asynchronous active-low reset
//   arb_req/arb_gnt      per-requestor request and encoded grant from the arbiter
//   req_data/req_last    flattened per-requestor beat payload and final-beat flags
//   req_ack              one-hot, combinational: owner's beat consumed this cycle
//   out_valid/out_data/out_src/out_last/out_ready  registered output handshake
//   busy                 controller owns a burst (XFER or RELEASE)
module arb_xfer_ctrl
  import arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                      arb_clk,
  input  logic                      arb_rst_n,
  input  logic [NUM_REQ-1:0]        arb_req,
  input  gnt_t                      arb_gnt,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output gnt_t                      out_src,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  xfer_state_e       state_q, state_d;
  gnt_t              owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              last_loaded_q, last_loaded_d;

  logic              load;
  logic              ld_last;
  logic [DATA_W-1:0] ld_data;

  assign ld_data = req_data[int'(owner_q) * DATA_W +: DATA_W];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    beat_cnt_d    = beat_cnt_q;
    last_loaded_d = last_loaded_q;
    load          = 1'b0;
    req_ack       = '0;
    // A beat is final if the requestor says so or the burst hit its length cap.
    ld_last       = req_last[owner_q] | (beat_cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        // Grant 00 is only meaningful when requestor 0 is actually asking.
        if (arb_req[arb_gnt]) begin
          owner_d       = arb_gnt;
          beat_cnt_d    = '0;
          last_loaded_d = 1'b0;
          state_d       = XFER;
        end
      end
      XFER: begin
        // arb_gnt is deliberately not looked at here: ownership is fixed until release.
        load = arb_req[owner_q] & ~last_loaded_q & (~out_valid | out_ready);
        if (load) begin
          req_ack[owner_q] = 1'b1;
          beat_cnt_d       = beat_cnt_q + CNT_W'(1);
          last_loaded_d    = ld_last;
        end
        if (out_valid & out_ready & out_last) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // One dead cycle lets the arbiter re-evaluate before the next grant is sampled.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      beat_cnt_q    <= '0;
      last_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      beat_cnt_q    <= beat_cnt_d;
      last_loaded_q <= last_loaded_d;
    end
  end

  assign busy = (state_q != IDLE);

  arb_out_stage #(
    .DATA_W(DATA_W)
  ) u_out_stage (
    .arb_clk   (arb_clk),
    .arb_rst_n (arb_rst_n),
    .load      (load),
    .in_data   (ld_data),
    .in_src    (owner_q),
    .in_last   (ld_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// tb/tb_arb_xfer_ctrl.sv - self-checking bench for arb_xfer_ctrl
module tb_arb_xfer_ctrl;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;

  logic                arb_clk = 1'b0;
  logic                arb_rst_n;
  logic [3:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_last;
  logic [3:0]          req_ack;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_src;
  logic                out_last;
  logic                out_ready;
  logic                busy;

  arb_xfer_ctrl #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .arb_clk   (arb_clk),
    .arb_rst_n (arb_rst_n),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 arb_clk = ~arb_clk;

  int total = 0;
  int bad   = 0;

  // Per-requestor pending beats {last, data} and the beats expected at the output.
  logic [DATA_W:0] src_q [4][$];
  logic [DATA_W:0] exp_q [4][$];
  int              run_cnt [4];
  logic [3:0]      hold;

  logic [3:0]        obs_req, obs_ack;
  logic              obs_valid, obs_last, obs_busy, taken;
  logic [DATA_W-1:0] obs_data;
  logic [1:0]        obs_src;
  logic              exp_have;
  logic [DATA_W:0]   exp_beat;

  // Stand-in for the upstream fixed-priority arbiter: 1 > 3 > 2 > 0.
  function automatic logic [1:0] prio_gnt(input logic [3:0] r);
    if (r[1]) return 2'd1;
    if (r[3]) return 2'd3;
    if (r[2]) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < 4; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected output stream per source: a burst ends at a requested last or the cap.
  task automatic push_beat(input int s, input logic [DATA_W-1:0] d, input logic last);
    src_q[s].push_back({last, d});
    run_cnt[s]++;
    if (last || run_cnt[s] == MAX_BEATS) begin
      exp_q[s].push_back({1'b1, d});
      run_cnt[s] = 0;
    end else begin
      exp_q[s].push_back({1'b0, d});
    end
  endtask

  task automatic push_burst(input int s, input int n, input logic with_last);
    for (int k = 0; k < n; k++)
      push_beat(s, DATA_W'($urandom), with_last && (k == n - 1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      run_cnt[i] = 0;
    end
  endtask

  task automatic drive();
    logic [DATA_W:0] h;
    for (int i = 0; i < 4; i++) begin
      h = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      arb_req[i] = (src_q[i].size() != 0) && !hold[i];
      req_data[i*DATA_W +: DATA_W] = h[DATA_W-1:0];
      req_last[i] = h[DATA_W];
    end
    arb_gnt = prio_gnt(arb_req);
  endtask

  // One cycle: drive at negedge, observe 1ns later, apply pops at the posedge.
  task automatic step();
    drive();
    #1;
    obs_req   = arb_req;
    obs_ack   = req_ack;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_src   = out_src;
    obs_last  = out_last;
    obs_busy  = busy;
    taken     = out_valid & out_ready;
    exp_have  = 1'b0;
    exp_beat  = '0;
    if (taken && exp_q[obs_src].size() != 0) begin
      exp_have = 1'b1;
      exp_beat = exp_q[obs_src].pop_front();
    end
    @(posedge arb_clk);
    for (int i = 0; i < 4; i++)
      if (obs_ack[i] && src_q[i].size() != 0) src_q[i].delete(0);
    @(negedge arb_clk);
  endtask

  task automatic test_reset();
    #2 arb_rst_n = 1'b0;
    @(negedge arb_clk);
    @(negedge arb_clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_data, out_src, out_last} !== '0) begin bad++; $display("FAIL reset_out_payload got=%h want=0", {out_data, out_src, out_last}); end
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL reset_req_ack got=%b want=0000", req_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    arb_rst_n = 1'b1;
    @(negedge arb_clk);
  endtask

  task automatic test_basic();
    int first_ack = -1, first_val = -1, busy_cyc = 0, nbeats = 0, ack_bad = 0;
    out_ready = 1'b1; hold = '0;
    push_burst(1, 3, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_ack != 4'b0 && first_ack < 0) first_ack = c;
      if (obs_valid && first_val < 0) first_val = c;
      if (obs_busy) busy_cyc++;
      if (obs_ack !== 4'b0000 && obs_ack !== 4'b0010) ack_bad++;
      if (taken) begin
        nbeats++;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat || obs_src !== 2'd1) begin
          bad++; $display("FAIL basic_beat got src=%0d last=%b data=%h want src=1 beat=%h", obs_src, obs_last, obs_data, exp_beat);
        end
      end
    end
    total++; if (first_ack != 1) begin bad++; $display("FAIL basic_first_ack got=%0d want=1", first_ack); end
    total++; if (first_val != 2) begin bad++; $display("FAIL basic_first_valid got=%0d want=2", first_val); end
    total++; if (busy_cyc != 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=5", busy_cyc); end
    total++; if (nbeats != 3) begin bad++; $display("FAIL basic_beats got=%0d want=3", nbeats); end
    total++; if (ack_bad != 0) begin bad++; $display("FAIL basic_ack_onehot got=%0d bad acks want=0", ack_bad); end
  endtask

  task automatic test_grant_change();
    int last3 = -1, first1 = -1, nb = 0;
    bit pushed = 1'b0;
    logic [11:0] seq = '0;
    out_ready = 1'b1; hold = '0;
    push_burst(3, 4, 1'b1);
    for (int c = 0; c < 30; c++) begin
      step();
      if (!pushed && obs_ack[3]) begin push_burst(1, 2, 1'b1); pushed = 1'b1; end
      if (obs_ack[1] && first1 < 0) first1 = c;
      if (taken) begin
        nb++;
        seq = {seq[9:0], obs_src};
        if (obs_src == 2'd3 && obs_last) last3 = c;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat) begin
          bad++; $display("FAIL gnt_change_beat got last=%b data=%h want %h", obs_last, obs_data, exp_beat);
        end
      end
    end
    total++; if (nb != 6 || seq !== 12'hFF5) begin bad++; $display("FAIL gnt_change_order got n=%0d seq=%h want n=6 seq=ff5", nb, seq); end
    total++; if (first1 - last3 != 3) begin bad++; $display("FAIL gnt_change_regrant got=%0d want=3", first1 - last3); end
  endtask

  task automatic test_backpressure();
    int nb = 0;
    bit prev_stall = 1'b0;
    logic [DATA_W+3:0] prev_snap = '0;
    hold = '0;
    push_burst(2, 4, 1'b1);
    for (int c = 0; c < 30; c++) begin
      out_ready = !((c % 4) == 1 || (c % 4) == 2);
      step();
      if (prev_stall) begin
        total++;
        if ({obs_valid, obs_data, obs_src, obs_last} !== prev_snap) begin
          bad++; $display("FAIL bp_hold got=%h want=%h", {obs_valid, obs_data, obs_src, obs_last}, prev_snap);
        end
      end
      if (obs_valid && !out_ready) begin
        total++;
        if (obs_ack !== 4'b0) begin bad++; $display("FAIL bp_ack_when_full got=%b want=0000", obs_ack); end
      end
      if (taken) begin
        nb++;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat || obs_src !== 2'd2) begin
          bad++; $display("FAIL bp_beat got src=%0d last=%b data=%h want src=2 beat=%h", obs_src, obs_last, obs_data, exp_beat);
        end
      end
      prev_stall = obs_valid && !out_ready;
      prev_snap  = {obs_valid, obs_data, obs_src, obs_last};
    end
    total++; if (nb != 4 || !model_empty()) begin bad++; $display("FAIL bp_count got=%0d want=4", nb); end
  endtask

  task automatic test_max_beats();
    int acks_first = 0, nb = 0;
    bit seen_busy = 1'b0, first_done = 1'b0;
    logic last4 = 1'b0;
    out_ready = 1'b1; hold = '0;
    for (int k = 0; k < 4; k++) push_beat(0, DATA_W'($urandom), 1'b0);
    push_beat(0, DATA_W'($urandom), 1'b1);
    for (int c = 0; c < 25; c++) begin
      step();
      if (obs_busy) seen_busy = 1'b1;
      if (seen_busy && !obs_busy) first_done = 1'b1;
      if (obs_ack[0] && !first_done) acks_first++;
      if (taken) begin
        nb++;
        if (nb == 4) last4 = obs_last;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat || obs_src !== 2'd0) begin
          bad++; $display("FAIL max_beat got src=%0d last=%b data=%h want src=0 beat=%h", obs_src, obs_last, obs_data, exp_beat);
        end
      end
    end
    total++; if (acks_first != 4) begin bad++; $display("FAIL max_acks got=%0d want=4", acks_first); end
    total++; if (last4 !== 1'b1) begin bad++; $display("FAIL max_forced_last got=%b want=1", last4); end
    total++; if (nb != 5) begin bad++; $display("FAIL max_total_beats got=%0d want=5", nb); end
  endtask

  task automatic test_no_grant();
    bit busy_seen = 1'b0;
    int nb = 0;
    out_ready = 1'b1; hold = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (obs_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen) begin bad++; $display("FAIL nogrant_busy got=1 want=0"); end
    push_burst(0, 1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      if (taken) begin
        nb++;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat || obs_src !== 2'd0) begin
          bad++; $display("FAIL nogrant_owner0 got src=%0d data=%h want src=0 beat=%h", obs_src, obs_data, exp_beat);
        end
      end
    end
    total++; if (nb != 1) begin bad++; $display("FAIL nogrant_count got=%0d want=1", nb); end
  endtask

  task automatic test_reset_mid();
    int nb = 0;
    bit busy_seen = 1'b0;
    out_ready = 1'b1; hold = '0;
    push_burst(2, 5, 1'b1);
    for (int c = 0; c < 20 && nb < 2; c++) begin
      step();
      if (taken) nb++;
    end
    total++; if (nb != 2) begin bad++; $display("FAIL rst_mid_reach got=%0d want=2", nb); end
    #2 arb_rst_n = 1'b0;
    #1;
    total++; if ({out_valid, out_data, out_src, out_last} !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%h want=0", {out_valid, out_data, out_src, out_last}); end
    total++; if (req_ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ack_busy got ack=%b busy=%b want 0000/0", req_ack, busy); end
    clear_model();
    drive();
    @(negedge arb_clk);
    arb_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (obs_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen) begin bad++; $display("FAIL rst_mid_idle got busy=1 want=0"); end
    nb = 0;
    push_burst(1, 2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      if (taken) begin
        nb++;
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat || obs_src !== 2'd1) begin
          bad++; $display("FAIL rst_mid_fresh got src=%0d data=%h want src=1 beat=%h", obs_src, obs_data, exp_beat);
        end
      end
    end
    total++; if (nb != 2) begin bad++; $display("FAIL rst_mid_fresh_count got=%0d want=2", nb); end
  endtask

  task automatic test_random();
    bit locked = 1'b0;
    logic [1:0] lock_src = '0;
    int s;
    for (int c = 0; c < 700; c++) begin
      if (c < 400) begin
        if ($urandom_range(0, 4) == 0) begin
          s = $urandom_range(0, 3);
          if (src_q[s].size() < 8) push_burst(s, $urandom_range(1, 6), 1'b1);
        end
        for (int i = 0; i < 4; i++) hold[i] = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if (model_empty() && !obs_busy) break;
        hold = '0;
        out_ready = 1'b1;
      end
      step();
      total++;
      if ((obs_ack & (obs_ack - 4'd1)) != 4'd0 || (obs_ack & ~obs_req) != 4'd0 ||
          (obs_ack != 4'd0 && obs_valid && !out_ready)) begin
        bad++; $display("FAIL rand_ack_rule got ack=%b req=%b valid=%b ready=%b want legal ack", obs_ack, obs_req, obs_valid, out_ready);
      end
      if (taken) begin
        total++;
        if (!exp_have || {obs_last, obs_data} !== exp_beat) begin
          bad++; $display("FAIL rand_beat got src=%0d last=%b data=%h want %h", obs_src, obs_last, obs_data, exp_beat);
        end
        total++;
        if (locked && obs_src !== lock_src) begin
          bad++; $display("FAIL rand_atomic got src=%0d want src=%0d", obs_src, lock_src);
        end
        locked   = !obs_last;
        lock_src = obs_src;
      end
    end
    total++; if (!model_empty() || busy) begin bad++; $display("FAIL rand_drain got busy=%b undrained want all drained", busy); end
  endtask

  initial begin
    arb_rst_n = 1'b1;
    out_ready = 1'b0;
    hold      = '0;
    arb_req   = '0;
    arb_gnt   = '0;
    req_data  = '0;
    req_last  = '0;
    clear_model();
    test_reset();
    test_basic();
    test_grant_change();
    test_backpressure();
    test_max_beats();
    test_no_grant();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
